// File: rtl/hazard_ctrl.sv
// Load-use stall / branch flush controller with zero-latency Mealy outputs.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_ex_MemRead,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        branch_taken,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic [1:0]  hz_state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        BAD   = 2'b11
    } state_t;

    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, next_state;
    logic [3:0] count, next_count;
    logic       load_use;
    logic       do_stall;
    logic       do_flush;

    assign load_use = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // The illegal encoding recovers first; otherwise a taken branch overrides
    // everything, including an in-progress stall.
    always_comb begin
        next_state = state;
        next_count = count;
        do_stall   = 1'b0;
        do_flush   = 1'b0;
        if (state == BAD) begin
            next_state = IDLE;
            next_count = 4'd0;
        end else if (branch_taken) begin
            do_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = FLUSH;
                next_count = FLUSH_LOAD;
            end else begin
                next_state = IDLE;
                next_count = 4'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_use) begin
                        do_stall = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            next_state = STALL;
                            next_count = STALL_LOAD;
                        end
                    end
                end
                STALL: begin
                    do_stall   = 1'b1;
                    next_count = count - 4'd1;
                    if (count <= 4'd1) begin
                        next_state = IDLE;
                        next_count = 4'd0;
                    end
                end
                FLUSH: begin
                    do_flush   = 1'b1;
                    next_count = count - 4'd1;
                    if (count <= 4'd1) begin
                        next_state = IDLE;
                        next_count = 4'd0;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_count = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        PC_write     = ~do_stall;
        IF_ID_write  = ~do_stall;
        IF_ID_Flush  = do_flush;
        ID_EX_Flush  = do_flush | do_stall;
        EX_MEM_Flush = do_flush;
        hz_state     = state;
        if (reset) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            hz_state     = IDLE;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!PC_write) stall_q <= stall_q + 32'd1;
            if (EX_MEM_Flush) flush_q <= flush_q + 32'd1;
        end
    end

    // Registered clear lands one edge late, so mask the first reset cycle too.
    assign stall_cnt = reset ? 32'd0 : stall_q;
    assign flush_cnt = reset ? 32'd0 : flush_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven scoreboard bench for hazard_ctrl; three instances with different
// stall/flush lengths share one stimulus bus.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr;
    logic [4:0]  rd, rs1, rs2;
    logic        br;

    logic        pc_a, ifw_a, iff_a, idf_a, exf_a;
    logic [1:0]  st_a;
    logic [31:0] sc_a, fc_a;
    logic        pc_b, ifw_b, iff_b, idf_b, exf_b;
    logic [1:0]  st_b;
    logic [31:0] sc_b, fc_b;
    logic        pc_c, ifw_c, iff_c, idf_c, exf_c;
    logic [1:0]  st_c;
    logic [31:0] sc_c, fc_c;

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .id_ex_MemRead(mr), .id_ex_rd(rd),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .branch_taken(br),
        .PC_write(pc_a), .IF_ID_write(ifw_a), .IF_ID_Flush(iff_a),
        .ID_EX_Flush(idf_a), .EX_MEM_Flush(exf_a), .hz_state(st_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a));

    hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .id_ex_MemRead(mr), .id_ex_rd(rd),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .branch_taken(br),
        .PC_write(pc_b), .IF_ID_write(ifw_b), .IF_ID_Flush(iff_b),
        .ID_EX_Flush(idf_b), .EX_MEM_Flush(exf_b), .hz_state(st_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b));

    hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .id_ex_MemRead(mr), .id_ex_rd(rd),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .branch_taken(br),
        .PC_write(pc_c), .IF_ID_write(ifw_c), .IF_ID_Flush(iff_c),
        .ID_EX_Flush(idf_c), .EX_MEM_Flush(exf_c), .hz_state(st_c),
        .stall_cnt(sc_c), .flush_cnt(fc_c));

    // Expected word: {PC_write, IF_ID_write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, hz_state}
    localparam logic [6:0] N = 7'b1100000;
    localparam logic [6:0] S = 7'b0001000;
    localparam logic [6:0] F = 7'b1111100;
    localparam logic [6:0] R = 7'b0011100;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t        tbl[32];
    logic [6:0]  exp_q[$];
    int          nvec  = 0;
    int          nfail = 0;
    logic [31:0] acc_stall = 32'd0;
    logic [31:0] acc_flush = 32'd0;

    function automatic vec_t mk(input logic r, input logic m, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic b, input logic [6:0] e);
        vec_t v;
        v.rst = r; v.mr = m; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.br = b; v.exp = e;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int which, input int idx);
        logic [6:0]  got, want;
        logic [31:0] es, ef;
        reset = v.rst; mr = v.mr; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; br = v.br;
        exp_q.push_back(v.exp);
        @(negedge clk);
        case (which)
            0:       got = {pc_a, ifw_a, iff_a, idf_a, exf_a, st_a};
            1:       got = {pc_b, ifw_b, iff_b, idf_b, exf_b, st_b};
            default: got = {pc_c, ifw_c, iff_c, idf_c, exf_c, st_c};
        endcase
        want = exp_q.pop_front();
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL ctrl dut%0d vec %0d: got %b required %b", which, idx, got, want);
        end
        if (which == 0) begin
`ifdef HAZARD_PERF_EN
            es = v.rst ? 32'd0 : acc_stall;
            ef = v.rst ? 32'd0 : acc_flush;
`else
            es = 32'd0;
            ef = 32'd0;
`endif
            nvec++;
            if (sc_a !== es || fc_a !== ef) begin
                nfail++;
                $display("FAIL perf vec %0d: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                         idx, sc_a, fc_a, es, ef);
            end
            if (v.rst) begin
                acc_stall = 32'd0;
                acc_flush = 32'd0;
            end else begin
                if (!v.exp[6]) acc_stall = acc_stall + 32'd1;
                if (v.exp[2])  acc_flush = acc_flush + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mr = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; br = 1'b0;

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, R);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, R);
        tbl[2]  = mk(0, 0, 5, 1, 5, 0, N);
        tbl[3]  = mk(0, 1, 0, 0, 2, 0, N);
        tbl[4]  = mk(0, 1, 5, 5, 2, 0, S);
        tbl[5]  = mk(0, 0, 5, 5, 2, 0, S | 7'd1);
        tbl[6]  = mk(0, 0, 5, 5, 2, 0, S | 7'd1);
        tbl[7]  = mk(0, 0, 5, 5, 2, 0, N);
        tbl[8]  = mk(0, 1, 7, 1, 7, 0, S);
        tbl[9]  = mk(0, 1, 7, 1, 7, 0, S | 7'd1);
        tbl[10] = mk(0, 1, 7, 1, 7, 0, S | 7'd1);
        tbl[11] = mk(0, 1, 7, 1, 7, 0, S);
        tbl[12] = mk(0, 1, 7, 1, 7, 1, F | 7'd1);
        tbl[13] = mk(0, 0, 7, 1, 7, 0, F | 7'd2);
        tbl[14] = mk(0, 0, 7, 1, 7, 0, N);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, F);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, F | 7'd2);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, F | 7'd2);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, N);
        tbl[19] = mk(0, 1, 5, 5, 2, 1, F);
        tbl[20] = mk(0, 1, 5, 5, 2, 0, F | 7'd2);
        tbl[21] = mk(0, 1, 5, 5, 2, 0, S);
        tbl[22] = mk(0, 0, 5, 5, 2, 0, S | 7'd1);
        tbl[23] = mk(1, 1, 5, 5, 2, 0, R);
        tbl[24] = mk(0, 0, 5, 5, 2, 0, N);
        tbl[25] = mk(0, 0, 5, 5, 2, 0, N);
        tbl[26] = mk(0, 1, 3, 9, 3, 0, S);
        tbl[27] = mk(0, 0, 3, 9, 3, 0, S | 7'd1);
        tbl[28] = mk(0, 0, 3, 9, 3, 1, F | 7'd1);
        tbl[29] = mk(1, 0, 3, 9, 3, 0, R);
        tbl[30] = mk(0, 0, 3, 9, 3, 0, N);
        tbl[31] = mk(0, 1, 4, 3, 2, 0, N);

        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) run_vec(tbl[i], 0, i);

        // Single-cycle stall: bubble only in the hazard cycle, state never leaves IDLE.
        run_vec(mk(1, 0, 0, 0, 0, 0, R), 1, 100);
        run_vec(mk(0, 1, 5, 0, 5, 0, S), 1, 101);
        run_vec(mk(0, 0, 5, 0, 5, 0, N), 1, 102);

        // Branch in the second stall cycle aborts the stall with a one-cycle flush.
        run_vec(mk(1, 0, 0, 0, 0, 0, R), 2, 200);
        run_vec(mk(0, 1, 5, 0, 5, 0, S), 2, 201);
        run_vec(mk(0, 0, 5, 0, 5, 1, F | 7'd1), 2, 202);
        run_vec(mk(0, 0, 5, 0, 5, 0, N), 2, 203);
        run_vec(mk(0, 0, 5, 0, 5, 0, N), 2, 204);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter STALL_CYCLES, default 1, total load-use stall cycles per hazard (legal 1..15).
REQ-002 Parameter FLUSH_CYCLES, default 1, total flush cycles per taken branch (legal 1..15).
REQ-003 clk  in  1  rising-edge clock; one clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_ex_MemRead  in  1  MemRead held in the ID/EX register.
REQ-006 id_ex_rd  in  5  destination register held in ID/EX.
REQ-007 if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in IF/ID.
REQ-008 branch_taken  in  1  taken branch resolved in MEM (EX/MEM Branch & zero).
REQ-009 PC_write  out  1  1 = PC advances.
REQ-010 IF_ID_write  out  1  1 = IF/ID loads.
REQ-011 IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  synchronous clear of the named pipeline register.
REQ-012 hz_state  out  2  current FSM state.
REQ-013 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-014 load_use SHALL be id_ex_MemRead & (id_ex_rd != 0) & (id_ex_rd == if_id_rs1 | id_ex_rd == if_id_rs2).
REQ-015 FSM states: IDLE=2'b00, STALL=2'b01, FLUSH=2'b10; 2'b11 SHALL return to IDLE on the next edge with all outputs at IDLE values.
REQ-016 IDLE, no hazard: PC_write=1, IF_ID_write=1, all flushes 0.
REQ-017 IDLE with load_use and no branch_taken: same cycle PC_write=0, IF_ID_write=0, ID_EX_Flush=1 (bubble); if STALL_CYCLES>1, go to STALL with remaining count = STALL_CYCLES-1, else stay IDLE.
REQ-018 STALL: outputs as in REQ-017; decrement count each cycle; return to IDLE on the edge where count reaches 0; load_use is ignored in STALL.
REQ-019 branch_taken in any state SHALL, the same cycle, assert IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush with PC_write=1, IF_ID_write=1, and SHALL take priority over load_use and abort any STALL.
REQ-020 If FLUSH_CYCLES>1, branch_taken SHALL load the count with FLUSH_CYCLES-1 and enter FLUSH; FLUSH holds the REQ-019 outputs, decrements, and returns to IDLE on the edge where count reaches 0.
REQ-021 branch_taken during FLUSH SHALL reload the count with FLUSH_CYCLES-1.
REQ-022 Zero-latency Mealy outputs: hazard visible in cycle t produces control outputs in cycle t.
REQ-023 Count register SHALL be 4 bits.

Reset
REQ-024 While reset=1: PC_write=0, IF_ID_write=0, all three flushes=1, hz_state=IDLE, count=0, stall_cnt=flush_cnt=0.
REQ-025 reset asserted mid-STALL or mid-FLUSH SHALL abort it; first cycle after reset behaves as IDLE.

Configuration
REQ-026 Macro HAZARD_PERF_EN defined: stall_cnt SHALL increment every cycle PC_write=0 (reset excluded); flush_cnt SHALL increment every cycle EX_MEM_Flush=1 (reset excluded); both wrap from 32'hFFFFFFFF to 0.
REQ-027 Macro HAZARD_PERF_EN undefined: stall_cnt and flush_cnt ports SHALL remain and be driven constant 0; no counter registers inferred.

Verification
REQ-028 STALL_CYCLES=1: id_ex_MemRead=1, id_ex_rd=5, if_id_rs2=5 for one cycle -> PC_write=0, IF_ID_write=0, ID_EX_Flush=1 that cycle only; hz_state stays 00.
REQ-029 STALL_CYCLES=3: same hazard for one cycle then cleared -> PC_write=0 for exactly 3 cycles, hz_state=01 for cycles 2-3; stall_cnt=3 with HAZARD_PERF_EN.
REQ-030 id_ex_rd=0, if_id_rs1=0, id_ex_MemRead=1 -> no stall; PC_write=1.
REQ-031 STALL_CYCLES=3, branch_taken=1 in second stall cycle -> that cycle all flushes=1, PC_write=1; next cycle IDLE with no stall.
REQ-032 FLUSH_CYCLES=2, branch_taken pulses twice one cycle apart -> flushes held 3 cycles total; flush_cnt=3.
REQ-033 reset=1 during STALL -> flushes=1, PC_write=0, counters=0; after release, no hazard -> PC_write=1, hz_state=00.
